// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
//
// Program-counter stage of the single-cycle core. Holds the architectural PC
// and sequences BOOT -> RUN -> {HALT | FAULT}. Each RUN cycle it either loads
// the next-PC selector output, holds on stall, or traps on a misaligned
// target. It also keeps retired-instruction and taken-redirect counters for
// debug.
//
// Parameters:
//   RESET_VECTOR      PC loaded on reset (must be word-aligned)
//
// Ports:
//   clk               system clock, all state updates on the rising edge
//   rst_n             synchronous active-low reset
//   next_pc_i         next PC from the next-PC 2:1 selector
//   pc_sel_i          1 = next_pc_i is a branch/jump target (counting only)
//   stall_i           hold the PC this cycle
//   halt_i            stop fetching, sticky until reset
//   pc_o              current PC (registered)
//   pc_plus4_o        pc_o + 4, combinational, wraps modulo 2^32
//   valid_o           pc_o addresses a real instruction this cycle
//   misalign_o        sticky misaligned-target fault flag
//   fault_pc_o        offending next_pc_i captured at the fault
//   halted_o          1 while in HALT
//   instr_count_o     retired-instruction count (wraps)
//   redirect_count_o  taken-redirect count (wraps)
// -----------------------------------------------------------------------------
module pc_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] next_pc_i,
   input  logic        pc_sel_i,
   input  logic        stall_i,
   input  logic        halt_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic        valid_o,
   output logic        misalign_o,
   output logic [31:0] fault_pc_o,
   output logic        halted_o,
   output logic [31:0] instr_count_o,
   output logic [31:0] redirect_count_o
);

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALT,
      FAULT
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [31:0] pc_nxt;
   logic        valid_nxt;
   logic        misalign_nxt;
   logic [31:0] fault_pc_nxt;
   logic        halted_nxt;
   logic [31:0] instr_count_nxt;
   logic [31:0] redirect_count_nxt;

   logic        target_misaligned;

   // Instructions are word-aligned; any low-order bit set is a bad target.
   assign target_misaligned = |next_pc_i[1:0];

   // Feeds the PC+4 adder path of the next-PC selector; wraps naturally.
   assign pc_plus4_o = pc_o + 32'd4;

   // --------------------------------------------------------------------------
   // State register and registered outputs
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= BOOT;
         pc_o             <= RESET_VECTOR;
         valid_o          <= 1'b0;
         misalign_o       <= 1'b0;
         fault_pc_o       <= '0;
         halted_o         <= 1'b0;
         instr_count_o    <= '0;
         redirect_count_o <= '0;
      end else begin
         state            <= state_nxt;
         pc_o             <= pc_nxt;
         valid_o          <= valid_nxt;
         misalign_o       <= misalign_nxt;
         fault_pc_o       <= fault_pc_nxt;
         halted_o         <= halted_nxt;
         instr_count_o    <= instr_count_nxt;
         redirect_count_o <= redirect_count_nxt;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state and next-output logic
   // --------------------------------------------------------------------------
   always_comb begin
      // Default: everything holds. This covers stall in RUN and both
      // terminal states without further assignments.
      state_nxt          = state;
      pc_nxt             = pc_o;
      valid_nxt          = valid_o;
      misalign_nxt       = misalign_o;
      fault_pc_nxt       = fault_pc_o;
      halted_nxt         = halted_o;
      instr_count_nxt    = instr_count_o;
      redirect_count_nxt = redirect_count_o;

      unique case (state)
         BOOT: begin
            // Inputs are ignored; the reset-vector fetch becomes valid next.
            state_nxt = RUN;
            valid_nxt = 1'b1;
         end

         RUN: begin
            // Priority: halt, then stall, then the alignment check. A stalled
            // edge never traps, even with a misaligned target presented.
            if (halt_i) begin
               state_nxt  = HALT;
               valid_nxt  = 1'b0;
               halted_nxt = 1'b1;
            end else if (stall_i) begin
               state_nxt = RUN;
            end else if (target_misaligned) begin
               state_nxt    = FAULT;
               valid_nxt    = 1'b0;
               misalign_nxt = 1'b1;
               fault_pc_nxt = next_pc_i;
            end else begin
               pc_nxt          = next_pc_i;
               instr_count_nxt = instr_count_o + 32'd1;
               if (pc_sel_i) begin
                  redirect_count_nxt = redirect_count_o + 32'd1;
               end
            end
         end

         HALT: begin
            state_nxt = HALT;
         end

         FAULT: begin
            state_nxt = FAULT;
         end

         default: begin
            state_nxt = BOOT;
         end
      endcase
   end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] next_pc;
   logic        pc_sel;
   logic        stall;
   logic        halt;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        valid;
   logic        misalign;
   logic [31:0] fault_pc;
   logic        halted;
   logic [31:0] instr_count;
   logic [31:0] redirect_count;

   int unsigned errors = 0;
   int unsigned checks = 0;

   pc_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .next_pc_i        (next_pc),
      .pc_sel_i         (pc_sel),
      .stall_i          (stall),
      .halt_i           (halt),
      .pc_o             (pc),
      .pc_plus4_o       (pc_plus4),
      .valid_o          (valid),
      .misalign_o       (misalign),
      .fault_pc_o       (fault_pc),
      .halted_o         (halted),
      .instr_count_o    (instr_count),
      .redirect_count_o (redirect_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Reference model: architectural view of the PC stage.
   // booting is implied by "not valid, not halted, not faulted".
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [31:0] pc;
      logic        valid;
      logic        misalign;
      logic [31:0] fault_pc;
      logic        halted;
      logic [31:0] ic;
      logic [31:0] rc;
   } exp_t;

   exp_t m;
   exp_t exp_q[$];

   function automatic exp_t model_edge(input exp_t s, input logic r, input logic [31:0] npc,
                                       input logic sel, input logic st, input logic hl);
      exp_t n;
      n = s;
      if (!r) begin
         n.pc = 32'h0; n.valid = 0; n.misalign = 0; n.fault_pc = 0;
         n.halted = 0; n.ic = 0; n.rc = 0;
      end else if (!s.valid && !s.halted && !s.misalign) begin
         n.valid = 1;
      end else if (s.valid) begin
         if (hl) begin
            n.valid = 0; n.halted = 1;
         end else if (st) begin
            n = s;
         end else if (npc % 4 != 0) begin
            n.valid = 0; n.misalign = 1; n.fault_pc = npc;
         end else begin
            n.pc = npc;
            n.ic = s.ic + 1;
            if (sel) n.rc = s.rc + 1;
         end
      end
      return n;
   endfunction

   // Drive one cycle of stimulus and queue what the DUT must show after the edge.
   task automatic step(input logic r, input logic [31:0] npc, input logic sel,
                       input logic st, input logic hl, input logic preload_wrap);
      @(posedge clk);
      #2;
      if (preload_wrap) begin
         force dut.instr_count_o = 32'hFFFF_FFFF;
         #1;
         release dut.instr_count_o;
         m.ic = 32'hFFFF_FFFF;
      end
      rst_n   = r;
      next_pc = npc;
      pc_sel  = sel;
      stall   = st;
      halt    = hl;
      m = model_edge(m, r, npc, sel, st, hl);
      exp_q.push_back(m);
   endtask

   task automatic run(input logic [31:0] npc, input logic sel);
      step(1'b1, npc, sel, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(1'b0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0); // BOOT -> RUN edge
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: one expectation per clock edge, compared just after the edge.
   // ---------------------------------------------------------------------------
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc",             pc,             e.pc);
            chk("pc_plus4",       pc_plus4,       e.pc + 32'd4);
            chk("valid",          {31'b0, valid}, {31'b0, e.valid});
            chk("misalign",       {31'b0, misalign}, {31'b0, e.misalign});
            chk("fault_pc",       fault_pc,       e.fault_pc);
            chk("halted",         {31'b0, halted}, {31'b0, e.halted});
            chk("instr_count",    instr_count,    e.ic);
            chk("redirect_count", redirect_count, e.rc);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic [31:0] npc;
      logic        r, st, hl;
      rst_n = 1'b0; next_pc = 32'h4; pc_sel = 0; stall = 0; halt = 0;
      m = '{pc: 0, valid: 0, misalign: 0, fault_pc: 0, halted: 0, ic: 0, rc: 0};

      // Reset and boot, then first retire to 0x4.
      step(1'b0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
      run(32'h4, 1'b0);

      // Redirect held by a 3-cycle stall.
      run(32'h8, 1'b0);
      run(32'hC, 1'b0);
      run(32'h10, 1'b0);
      for (int unsigned i = 0; i < 3; i++) step(1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
      run(32'h40, 1'b1);

      // Stalled misaligned target must not trap; unstalled one does.
      step(1'b1, 32'h43, 1'b0, 1'b1, 1'b0, 1'b0);
      run(32'h42, 1'b1);
      for (int unsigned i = 0; i < 10; i++)
         step(1'b1, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);

      // Halt beats stall and misalignment; HALT is sticky.
      do_reset(1);
      run(32'h100, 1'b1);
      step(1'b1, 32'h3, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int unsigned i = 0; i < 4; i++) step(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0);

      // Wrap of pc+4 and of the retired-instruction counter.
      do_reset(1);
      run(32'hFFFF_FFFC, 1'b1);
      run(m.pc + 32'd4, 1'b0);
      step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1);
      run(32'h20, 1'b0); // self-loop retires

      // Reset mid-run with five retires behind it.
      do_reset(1);
      for (int unsigned i = 1; i <= 5; i++) run(32'(i * 8), 1'($urandom));
      step(1'b0, 32'h50, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h54, 1'b1, 1'b0, 1'b0, 1'b0);
      run(32'h58, 1'b1);

      // Randomized traffic.
      for (int unsigned i = 0; i < 600; i++) begin
         r  = ($urandom_range(0, 59) != 0);
         if ((m.halted || m.misalign) && $urandom_range(0, 4) == 0) r = 1'b0;
         st = ($urandom_range(0, 3) == 0);
         hl = ($urandom_range(0, 39) == 0);
         npc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         if ($urandom_range(0, 29) == 0) npc[1:0] = 2'($urandom_range(1, 3));
         step(r, npc, 1'($urandom), st, hl, 1'b0);
      end

      repeat (2) @(posedge clk);
      #3;
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
